control_bandas: RTL and testbench

Sequencer for the three-band recursive filter datapath. On each new input sample it runs the shared recursive filter once per band (low, mid, high), selecting the band's coefficient set each time. After each pass it drives the 2-bit counter input of the decoder/register bank so the filter result is captured into that band's parallel output register. When all three registers hold fresh data it pulses a valid strobe, and it flags sample overruns and filter timeouts.

---
 rtl/control_bandas.sv | 145 ++++++++++++++
 tb/tb_control_bandas.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_bandas.sv
// Three-band sequencer for the shared recursive filter: runs one filter pass per band
// (low, mid, high), strobes each result into its band register, then pulses salidas_validas.
module control_bandas #(
    parameter int TIMEOUT = 200,
    parameter int TW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          muestra_lista,
    input  logic          filtro_listo,
    input  logic          clr_error,
    output logic          inicio_filtro,
    output logic [1:0]    sel_coef,
    output logic [1:0]    cont_deco,
    output logic          retener,
    output logic          salidas_validas,
    output logic          ocupado,
    output logic          sobrecarga,
    output logic          error_filtro
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARRANQUE = 3'd1,
        ESPERA   = 3'd2,
        CARGA1   = 3'd3,
        CARGA2   = 3'd4,
        FIN      = 3'd5
    } state_t;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [1:0]    LAST_BAND = 2'd2;

    state_t         state_reg;
    logic [1:0]     b_reg;
    logic [TW-1:0]  tmo_cnt_reg;

    logic           set_ovr;
    logic           set_err;

    // A sample that arrives while a sequence is running is dropped and flagged.
    assign set_ovr = muestra_lista && (state_reg != IDLE);
    // Expiry only counts when the filter did not answer on that same cycle.
    assign set_err = (state_reg == ESPERA) && !filtro_listo && (tmo_cnt_reg == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            b_reg           <= 2'd0;
            tmo_cnt_reg     <= '0;
            inicio_filtro   <= 1'b0;
            sel_coef        <= 2'd0;
            cont_deco       <= 2'd0;
            retener         <= 1'b0;
            salidas_validas <= 1'b0;
            ocupado         <= 1'b0;
            sobrecarga      <= 1'b0;
            error_filtro    <= 1'b0;
        end else begin
            inicio_filtro   <= 1'b0;
            cont_deco       <= 2'd0;
            salidas_validas <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (muestra_lista) begin
                        state_reg     <= ARRANQUE;
                        b_reg         <= 2'd0;
                        sel_coef      <= 2'd0;
                        inicio_filtro <= 1'b1;
                        ocupado       <= 1'b1;
                    end
                end

                ARRANQUE: begin
                    state_reg   <= ESPERA;
                    tmo_cnt_reg <= '0;
                end

                ESPERA: begin
                    if (filtro_listo) begin
                        state_reg <= CARGA1;
                        cont_deco <= b_reg + 2'd1;
                        retener   <= 1'b1;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        // Abort the whole sample: nothing is loaded, no valid pulse.
                        state_reg <= IDLE;
                        b_reg     <= 2'd0;
                        sel_coef  <= 2'd0;
                        ocupado   <= 1'b0;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end

                CARGA1: begin
                    // Keep the filter output frozen one more cycle for the decoder's register stage.
                    state_reg <= CARGA2;
                end

                CARGA2: begin
                    retener <= 1'b0;
                    if (b_reg == LAST_BAND) begin
                        state_reg       <= FIN;
                        salidas_validas <= 1'b1;
                    end else begin
                        state_reg     <= ARRANQUE;
                        b_reg         <= b_reg + 2'd1;
                        sel_coef      <= b_reg + 2'd1;
                        inicio_filtro <= 1'b1;
                    end
                end

                FIN: begin
                    state_reg <= IDLE;
                    b_reg     <= 2'd0;
                    sel_coef  <= 2'd0;
                    ocupado   <= 1'b0;
                end

                default: begin
                    state_reg <= IDLE;
                    b_reg     <= 2'd0;
                    sel_coef  <= 2'd0;
                    retener   <= 1'b0;
                    ocupado   <= 1'b0;
                end
            endcase

            // Sticky flags: a set event in the same cycle as clr_error keeps the flag high.
            if (set_ovr) begin
                sobrecarga <= 1'b1;
            end else if (clr_error) begin
                sobrecarga <= 1'b0;
            end

            if (set_err) begin
                error_filtro <= 1'b1;
            end else if (clr_error) begin
                error_filtro <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_control_bandas.sv
// Scoreboard bench for control_bandas: scenarios are planned as expected output events
// (time, kind, value) and a negedge monitor matches what the DUT actually shows.
module tb_control_bandas;

    localparam int TIMEOUT = 200;

    localparam int K_BUSY   = 0;
    localparam int K_INICIO = 1;
    localparam int K_CARGA  = 2;
    localparam int K_HOLD   = 3;
    localparam int K_VALID  = 4;
    localparam int K_OVR    = 5;
    localparam int K_ERR    = 6;

    typedef struct {
        int t;
        int k;
        int v;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       muestra_lista = 1'b0;
    logic       filtro_listo = 1'b0;
    logic       clr_error = 1'b0;
    logic       inicio_filtro;
    logic [1:0] sel_coef;
    logic [1:0] cont_deco;
    logic       retener;
    logic       salidas_validas;
    logic       ocupado;
    logic       sobrecarga;
    logic       error_filtro;

    control_bandas #(.TIMEOUT(TIMEOUT), .TW(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .muestra_lista   (muestra_lista),
        .filtro_listo    (filtro_listo),
        .clr_error       (clr_error),
        .inicio_filtro   (inicio_filtro),
        .sel_coef        (sel_coef),
        .cont_deco       (cont_deco),
        .retener         (retener),
        .salidas_validas (salidas_validas),
        .ocupado         (ocupado),
        .sobrecarga      (sobrecarga),
        .error_filtro    (error_filtro)
    );

    always #5 clk = ~clk;

    // cyc = index of the last rising edge; inputs driven at a negedge are sampled at edge cyc+1,
    // and outputs seen at a negedge belong to time cyc+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  n_cmp = 0;
    int  n_bad = 0;
    ev_t exp_q[$];
    bit  sched_m[int];
    bit  sched_f[int];
    bit  sched_c[int];
    bit  sched_r[int];
    bit  rand_phase = 1'b1;
    bit  mon_en = 1'b0;
    bit  model_ovr = 1'b0;
    bit  model_err = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_ovr = 1'b0;
    logic prev_err = 1'b0;

    function automatic string kname(input int k);
        case (k)
            K_BUSY:   return "ocupado";
            K_INICIO: return "inicio";
            K_CARGA:  return "carga";
            K_HOLD:   return "hold";
            K_VALID:  return "valid";
            K_OVR:    return "sobrecarga";
            default:  return "error_filtro";
        endcase
    endfunction

    task automatic push(input int t, input int k, input int v);
        ev_t e;
        int  i;
        e.t = t;
        e.k = k;
        e.v = v;
        i = 0;
        while (i < exp_q.size() && (exp_q[i].t < t || (exp_q[i].t == t && exp_q[i].k < k))) i++;
        exp_q.insert(i, e);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Reference model: event times follow from the band-pass rules
    // (ARRANQUE, ESPERA for d+1 cycles, CARGA1, CARGA2) with plain arithmetic.
    task automatic plan_seq(input int t, input int d0, input int d1, input int d2,
                            input bit noise, input int rst_band, output int t_end);
        int a;
        int dd;
        a = t + 1;
        sched_m[t] = 1'b1;
        push(a, K_BUSY, 1);
        for (int k = 0; k < 3; k++) begin
            dd = (k == 0) ? d0 : ((k == 1) ? d1 : d2);
            push(a, K_INICIO, k);
            if (noise) sched_f[a] = 1'b1;
            if (dd >= TIMEOUT) begin
                if (!model_err) begin
                    push(a + 1 + TIMEOUT, K_ERR, 1);
                    model_err = 1'b1;
                end
                push(a + 1 + TIMEOUT, K_BUSY, 0);
                t_end = a + 1 + TIMEOUT;
                return;
            end
            sched_f[a + 1 + dd] = 1'b1;
            push(a + 2 + dd, K_CARGA, (k << 3) | 4 | (k + 1));
            if (k == rst_band) begin
                sched_r[a + 2 + dd] = 1'b1;
                push(a + 3 + dd, K_BUSY, 0);
                if (model_ovr) push(a + 3 + dd, K_OVR, 0);
                if (model_err) push(a + 3 + dd, K_ERR, 0);
                model_ovr = 1'b0;
                model_err = 1'b0;
                t_end = a + 3 + dd;
                return;
            end
            push(a + 3 + dd, K_HOLD, (k << 3) | 4);
            if (noise) begin
                sched_f[a + 2 + dd] = 1'b1;
                sched_f[a + 3 + dd] = 1'b1;
            end
            a = a + 4 + dd;
        end
        push(a, K_VALID, 1);
        push(a + 1, K_BUSY, 0);
        if (noise) begin
            sched_f[a] = 1'b1;
            sched_f[a + 1] = 1'b1;
        end
        t_end = a + 1;
    endtask

    task automatic plan_ovr(input int e);
        sched_m[e] = 1'b1;
        if (!model_ovr) begin
            push(e + 1, K_OVR, 1);
            model_ovr = 1'b1;
        end
    endtask

    task automatic plan_clr(input int e, input bit with_ovr);
        sched_c[e] = 1'b1;
        if (with_ovr) begin
            plan_ovr(e);
        end else if (model_ovr) begin
            push(e + 1, K_OVR, 0);
            model_ovr = 1'b0;
        end
        if (model_err) begin
            push(e + 1, K_ERR, 0);
            model_err = 1'b0;
        end
    endtask

    task automatic wait_until(input int tt);
        while (cyc < tt) @(posedge clk);
    endtask

    // Driver
    initial begin
        int e;
        forever begin
            @(negedge clk);
            e = cyc + 1;
            if (rand_phase) begin
                reset         = 1'b1;
                muestra_lista = 1'($urandom_range(0, 1));
                filtro_listo  = 1'($urandom_range(0, 1));
                clr_error     = 1'($urandom_range(0, 1));
            end else begin
                reset         = (sched_r.exists(e) != 0);
                muestra_lista = (sched_m.exists(e) != 0);
                filtro_listo  = (sched_f.exists(e) != 0);
                clr_error     = (sched_c.exists(e) != 0);
            end
        end
    end

    task automatic obs(input int now, input int k, input int v);
        n_cmp++;
        if (exp_q.size() > 0 && exp_q[0].t == now && exp_q[0].k == k) begin
            if (exp_q[0].v != v) begin
                n_bad++;
                $display("FAIL ev_%s t=%0d got=%0h expected=%0h", kname(k), now, v, exp_q[0].v);
            end
            void'(exp_q.pop_front());
        end else begin
            n_bad++;
            $display("FAIL unexpected_%s t=%0d got=%0h expected=none", kname(k), now, v);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        int now;
        if (mon_en) begin
            now = cyc + 1;
            while (exp_q.size() > 0 && exp_q[0].t < now) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_%s t=%0d got=none expected=%0h",
                         kname(exp_q[0].k), exp_q[0].t, exp_q[0].v);
                void'(exp_q.pop_front());
            end
            if (ocupado !== prev_busy) obs(now, K_BUSY, int'(ocupado));
            if (inicio_filtro) obs(now, K_INICIO, int'(sel_coef));
            if (cont_deco != 2'd0) obs(now, K_CARGA, int'({sel_coef, retener, cont_deco}));
            if (retener && cont_deco == 2'd0) obs(now, K_HOLD, int'({sel_coef, retener, cont_deco}));
            if (salidas_validas) begin
                obs(now, K_VALID, 1);
                $display("txn: salidas_validas at t=%0d", now);
            end
            if (sobrecarga !== prev_ovr) obs(now, K_OVR, int'(sobrecarga));
            if (error_filtro !== prev_err) obs(now, K_ERR, int'(error_filtro));
            prev_busy = ocupado;
            prev_ovr  = sobrecarga;
            prev_err  = error_filtro;
        end
    end

    // Watchdog
    initial begin
        repeat (60000) @(posedge clk);
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog got=running expected=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Stimulus / planning
    initial begin
        int t;
        int t_end;
        int e1;
        int prev_end;
        int gap;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_inicio", int'(inicio_filtro), 0);
        chk("rst_sel_coef", int'(sel_coef), 0);
        chk("rst_cont_deco", int'(cont_deco), 0);
        chk("rst_retener", int'(retener), 0);
        chk("rst_valid", int'(salidas_validas), 0);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_sobrecarga", int'(sobrecarga), 0);
        chk("rst_error", int'(error_filtro), 0);

        @(posedge clk);
        rand_phase = 1'b0;
        prev_busy  = 1'b0;
        prev_ovr   = 1'b0;
        prev_err   = 1'b0;
        mon_en     = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("idle_ocupado", int'(ocupado), 0);

        // Fast filter, then a back-to-back sample exactly at t+14
        @(posedge clk);
        t = cyc + 3;
        plan_seq(t, 0, 0, 0, 1'b0, -1, e1);
        plan_seq(e1, 0, 0, 0, 1'b1, -1, t_end);
        wait_until(t_end + 4);

        // Overrun at t+6 and in FIN (t+13), later cleared
        t = cyc + 3;
        plan_seq(t, 0, 0, 0, 1'b0, -1, t_end);
        plan_ovr(t + 6);
        plan_ovr(t + 13);
        plan_clr(t_end + 3, 1'b0);
        wait_until(t_end + 8);

        // Slow filter: filtro_listo 50 cycles after each inicio
        t = cyc + 3;
        plan_seq(t, 49, 49, 49, 1'b1, -1, t_end);
        wait_until(t_end + 4);

        // Timeout on the mid band, clear, then filtro_listo exactly on the expiry cycle
        t = cyc + 3;
        plan_seq(t, 0, TIMEOUT, 0, 1'b0, -1, t_end);
        plan_clr(t_end + 2, 1'b0);
        t = t_end + 4;
        plan_seq(t, 0, TIMEOUT - 1, 0, 1'b0, -1, t_end);
        plan_ovr(t + 3);
        plan_clr(t + 8, 1'b1);
        plan_clr(t_end + 1, 1'b0);
        wait_until(t_end + 6);

        // Reset during mid-band CARGA1, then restart
        t = cyc + 3;
        plan_ovr(t + 2);
        plan_seq(t, 0, 1, 0, 1'b0, 1, e1);
        plan_seq(e1, 0, 0, 0, 1'b0, -1, t_end);
        wait_until(t_end + 4);

        // Randomized sequences
        prev_end = cyc + 3;
        for (int i = 0; i < 25; i++) begin
            gap = $urandom_range(0, 3);
            t = prev_end + gap;
            plan_seq(t, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                     1'($urandom_range(0, 1)), -1, t_end);
            if ($urandom_range(0, 2) == 0) plan_ovr($urandom_range(t + 1, t_end - 1));
            if ($urandom_range(0, 3) == 0) plan_clr(t_end, 1'b0);
            prev_end = t_end;
            wait_until(t_end - 3);
        end
        wait_until(prev_end + 6);

        @(posedge clk);
        mon_en = 1'b0;
        while (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL never_seen_%s t=%0d got=none expected=%0h",
                     kname(exp_q[0].k), exp_q[0].t, exp_q[0].v);
            void'(exp_q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
